// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the balance-RAM port arbiter:
//   - arb_state_e : 2-bit FSM encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//   - REQ_INIT / REQ_TXN / REQ_DISP : requester index constants
//   - DATA_W : RAM word width (six 8-bit balances)
//   - CNT_W  : width of the read-latency counter (READ_LAT is 1..3)
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int DATA_W = 48;

    localparam int REQ_INIT = 0;
    localparam int REQ_TXN  = 1;
    localparam int REQ_DISP = 2;

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select for the RAM port arbiter.
// Requester 0 has absolute priority; requesters 1..N_REQ-1 are served
// round-robin starting after the one recorded in ptr_i.
//
// Ports:
//   req_i      in  N_REQ  request levels
//   ptr_i      in  IDX_W  last granted round-robin requester (1..N_REQ-1)
//   winner_o   out N_REQ  one-hot winner (all zero when no request)
//   win_idx_o  out IDX_W  index of the winner
//   valid_o    out 1      a winner exists
// -----------------------------------------------------------------------------
module arb_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] winner_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             valid_o
);
    import arb_pkg::*;

    int idx;

    always_comb begin
        winner_o  = '0;
        win_idx_o = '0;
        valid_o   = 1'b0;
        idx       = 0;
        if (req_i[REQ_INIT]) begin
            winner_o[REQ_INIT] = 1'b1;
            win_idx_o          = IDX_W'(REQ_INIT);
            valid_o            = 1'b1;
        end else begin
            // Walk the round-robin ring 1..N_REQ-1 starting just after ptr_i;
            // the first requester found wins.
            for (int k = 1; k < N_REQ; k++) begin
                idx = int'(ptr_i) + k;
                if (idx > N_REQ - 1) begin
                    idx = idx - (N_REQ - 1);
                end
                if (!valid_o && req_i[idx]) begin
                    winner_o[idx] = 1'b1;
                    win_idx_o     = IDX_W'(idx);
                    valid_o       = 1'b1;
                end
            end
        end
    end

endmodule : arb_pick

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
// Shares the single balance-RAM port among the starting-memory initialiser
// (0), the transaction controller (1) and the VGA money display (2). Each
// access is serialised as IDLE -> ISSUE -> [WAIT] -> DONE; read data is
// captured into rd_data and a one-cycle done strobe goes to the owner.
//
// Ports:
//   clock            in  1             system clock
//   resetn           in  1             asynchronous active-low reset
//   req              in  N_REQ         request levels, held until done
//   req_wren         in  N_REQ         per-requester write enable
//   req_access_type  in  N_REQ         per-requester access_type bit
//   req_data_in      in  N_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
//   grant            out N_REQ         one-hot owner of the port
//   done             out N_REQ         one-hot completion pulse
//   rd_data          out DATA_W        last captured read word
//   busy             out 1             state is not IDLE
//   ram_wren         out 1             RAM write enable
//   ram_access_type  out 1             RAM access_type
//   ram_data_in      out DATA_W        RAM write data
//   ram_result       in  DATA_W        RAM read data
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int DATA_W   = 48,
    parameter int N_REQ    = 3,
    parameter int READ_LAT = 1      // 1..3 cycles from issued read to valid ram_result
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_wren,
    input  logic [N_REQ-1:0]        req_access_type,
    input  logic [N_REQ*DATA_W-1:0] req_data_in,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    busy,
    output logic                    ram_wren,
    output logic                    ram_access_type,
    output logic [DATA_W-1:0]       ram_data_in,
    input  logic [DATA_W-1:0]       ram_result
);
    import arb_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic               cmd_wren_q, cmd_wren_d;
    logic               cmd_at_q, cmd_at_d;
    logic [DATA_W-1:0]  cmd_data_q, cmd_data_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic [N_REQ-1:0]   pick_winner;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .winner_o  (pick_winner),
        .win_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d    = state_q;
        cmd_wren_d = cmd_wren_q;
        cmd_at_d   = cmd_at_q;
        cmd_data_d = cmd_data_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_ISSUE;
                    grant_d    = pick_winner;
                    // Latch the command so the requester may drop or change
                    // its inputs once granted.
                    cmd_wren_d = req_wren[pick_idx];
                    cmd_at_d   = req_access_type[pick_idx];
                    cmd_data_d = req_data_in[int'(pick_idx)*DATA_W +: DATA_W];
                    // Only round-robin requesters move the pointer.
                    if (!pick_winner[REQ_INIT]) begin
                        ptr_d = pick_idx;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_wren_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(READ_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rd_data_d = ram_result;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Command register, grant, pointer, latency counter and read capture
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cmd_wren_q <= 1'b0;
            cmd_at_q   <= 1'b0;
            cmd_data_q <= '0;
            grant_q    <= '0;
            ptr_q      <= IDX_W'(REQ_DISP);
            cnt_q      <= '0;
            rd_data_q  <= '0;
        end else begin
            cmd_wren_q <= cmd_wren_d;
            cmd_at_q   <= cmd_at_d;
            cmd_data_q <= cmd_data_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Outputs: decoded only from registered state and registers, so an
    // asynchronous reset clears every RAM-side signal at once.
    always_comb begin
        busy            = (state_q != ST_IDLE);
        grant           = grant_q;
        done            = (state_q == ST_DONE) ? grant_q : '0;
        rd_data         = rd_data_q;
        ram_wren        = (state_q == ST_ISSUE) && cmd_wren_q;
        ram_access_type = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && cmd_at_q;
        ram_data_in     = (state_q == ST_ISSUE) ? cmd_data_q : '0;
    end

endmodule : ram_port_arbiter

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Sequences and shares the single 48-bit balance RAM port among three requesters: the starting-memory initialiser, the transaction memory controller and the VGA money display refresh. It sits between those requesters and the RAM instance. It serialises every access into one issue/complete handshake, captures read data and pulses a per-requester completion strobe. Requester 0 (init) has absolute priority. Requesters 1 and 2 alternate round-robin so the display cannot starve transactions, and transactions cannot starve the display.

## Interface
- DATA_W, 48, RAM word width (six 8-bit balances)
- N_REQ, 3, number of requesters (index 0 = init, 1 = transaction, 2 = display)
- READ_LAT, 1, RAM cycles from issued read to valid `ram_result` (1..3)
- clock  in  1  system clock (CLOCK_50 domain); single clock
- resetn  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester access request, level, held until matching `done`
- req_wren  in  N_REQ  per-requester write enable (1 = write, 0 = read)
- req_access_type  in  N_REQ  per-requester RAM access_type bit
- req_data_in  in  N_REQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W]
- grant  out  N_REQ  one-hot, requester currently owning the port
- done  out  N_REQ  one-hot, one-cycle completion pulse
- rd_data  out  DATA_W  last captured read word
- busy  out  1  high whenever state is not IDLE
- ram_wren  out  1  RAM write enable
- ram_access_type  out  1  RAM access_type
- ram_data_in  out  DATA_W  RAM write data
- ram_result  in  DATA_W  RAM read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, any req high: pick a winner, set grant, latch wren/access_type/data of the winner into the command register, go to ISSUE. No req: stay in IDLE.
- Pick rule:
  - req[0] high: requester 0 wins.
  - Otherwise round-robin between 1 and 2, starting after the last granted of those two. The pointer resets to 2, so 1 wins the first tie.
  - A grant to requester 0 does not move the pointer.
- ISSUE: drive `ram_wren`, `ram_access_type` and `ram_data_in` from the command register for exactly one cycle.
  - Write: go to DONE.
  - Read: go to WAIT with counter = READ_LAT-1.
- WAIT: `ram_wren` = 0 and `ram_access_type` is held. When the counter reaches 0, capture `rd_data <= ram_result` and go to DONE. Otherwise decrement.
- DONE: pulse `done[g]`, clear grant and `ram_*`, return to IDLE. A new arbitration can start the next cycle.
- Writes leave `rd_data` unchanged.
- Requester drops req or changes its inputs after grant: the latched command completes unaffected and done still pulses.
- Requester keeps req high after done: it is treated as a new request and rearbitrated in IDLE.
- Simultaneous req[1] and req[2] held continuously: grants alternate 1,2,1,2.
- resetn low at any time, mid-operation included: the state goes to IDLE immediately and asynchronously, and the aborted access gets no done.
- Reset values: all outputs are 0, the command register is 0 and the pointer is 2.

## Timing
- Every output is registered. `busy` and `grant` derive from state.
- Write: req first sampled at edge 0, ISSUE cycle 1, done high cycle 2. The request-to-done latency is 3 cycles.
- Read: req at edge 0, ISSUE cycle 1, WAIT cycles 2..1+READ_LAT, done and rd_data valid at cycle 2+READ_LAT. Default latency is 4 cycles.
- Back-to-back throughput: one write per 3 cycles (IDLE, ISSUE, DONE), one read per 3+READ_LAT cycles.
- `done` is never high for two consecutive cycles for the same index. `rd_data` is stable from its done cycle until the next read capture.

## Structure
- A shared package `arb_pkg` holds:
  - the state encoding (2-bit, IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - requester index constants REQ_INIT=0, REQ_TXN=1, REQ_DISP=2;
  - DATA_W.
- Sub-module `arb_pick`: combinational winner select from req plus pointer, outputting a one-hot winner and a valid flag. The top holds the FSM, the command register, the WAIT counter and the pointer.

## Test plan
- Reset value check: assert resetn=0, hold 3 cycles, release. Required response: all outputs 0, `busy`=0.
- Single write: req[1]=1, wren=1, data=48'h0A0B0C0D0E0F. Required response: `ram_wren`=1 with that data only in cycle 1, done[1] in cycle 2, `rd_data` unchanged.
- Single read: req[2]=1, wren=0, READ_LAT=1, `ram_result`=48'h112233445566 in cycle 2. Required response: done[2] and `rd_data`=48'h112233445566 in cycle 3.
- Contention: req[0], req[1] and req[2] all held high. Required response: grant order 0,0,... while req[0] stays high. After req[0] drops, the order is 1,2,1,2.
- Mid-operation changes: drop req[1] and change its data during ISSUE. Required response: the original data is written and done[1] still pulses.
- Reset mid-read: drive resetn=0 during WAIT. Required response: `ram_*` clear immediately, no done pulse, the next access is granted to requester 1 on a 1/2 tie.
